// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared types, display constants and helpers for the combination lock
package lock_pkg;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        OPEN    = 2'd1,
        PROGRAM = 2'd2,
        LOCKOUT = 2'd3
    } lock_state_t;

    localparam logic [3:0] DIG_BAD  = 4'hF;
    localparam logic [3:0] DIG_LOCK = 4'hE;
    localparam logic [3:0] DIG_OPEN = 4'h0;

    // Only meaningful for a word with exactly one bit set.
    function automatic logic [3:0] onehot_to_index(input logic [15:0] onehot);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (onehot[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/lock_fsm_multi_if.sv
// rtl/lock_fsm_multi_if.sv - button/program inputs and display/status outputs of the lock
interface lock_fsm_multi_if #(
    parameter int NUM_BUTTONS = 4,
    parameter int NUM_DIGITS  = 4
) ();

    logic [NUM_BUTTONS-1:0]  strobes;
    logic                    program_req;
    logic [4*NUM_DIGITS-1:0] display;
    logic [NUM_DIGITS-1:0]   points;
    logic [NUM_DIGITS-1:0]   enable_digits;
    logic                    unlocked;
    logic                    lockout;

    modport master (
        output strobes, program_req,
        input  display, points, enable_digits, unlocked, lockout
    );

    modport slave (
        input  strobes, program_req,
        output display, points, enable_digits, unlocked, lockout
    );

endinterface

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - loadable down-counter shared by the OPEN and LOCKOUT states
module lock_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/lock_fsm_multi.sv
// rtl/lock_fsm_multi.sv - parametrised combination lock with lockout, auto-relock and code programming
module lock_fsm_multi
    import lock_pkg::*;
#(
    parameter int                    NUM_BUTTONS    = 4,
    parameter int                    CODE_LEN       = 4,
    parameter int                    NUM_DIGITS     = 4,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h3210,
    parameter int                    MAX_FAILS      = 3,
    parameter int                    UNLOCK_CYCLES  = 50_000_000,
    parameter int                    LOCKOUT_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              reset,
    lock_fsm_multi_if.slave   bus
);

    localparam int MAX_CYC = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);

    lock_state_t             state_q;
    logic [4*CODE_LEN-1:0]   code_q;
    logic [4*CODE_LEN-1:0]   shadow_q;
    logic [4*CODE_LEN-1:0]   shadow_upd;
    logic [IDX_W-1:0]        idx_q;
    logic                    mismatch_q;
    logic [FAIL_W-1:0]       fail_q;
    logic [4*NUM_DIGITS-1:0] display_q;
    logic [NUM_DIGITS-1:0]   points_q;
    logic [NUM_DIGITS-1:0]   enable_q;
    logic                    unlocked_q;
    logic                    lockout_q;

    logic [15:0]      strobe_word;
    logic             any_strobe;
    logic             valid_sym;
    logic [3:0]       sym;
    logic             last_slot;
    logic             sym_miss;
    logic             code_ok;
    logic             code_bad;
    logic             fails_full;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic             tmr_done;

    assign strobe_word = 16'(bus.strobes);
    assign any_strobe  = |bus.strobes;
    assign valid_sym   = any_strobe && ((strobe_word & (strobe_word - 16'd1)) == 16'd0);
    assign sym         = onehot_to_index(strobe_word);
    assign last_slot   = (idx_q == IDX_W'(CODE_LEN - 1));
    assign sym_miss    = !valid_sym || (sym != code_q[4*int'(idx_q) +: 4]);
    assign code_ok     = (state_q == ENTRY) && any_strobe && last_slot && !mismatch_q && !sym_miss;
    assign code_bad    = (state_q == ENTRY) && any_strobe && last_slot && (mismatch_q || sym_miss);
    assign fails_full  = code_bad && (fail_q == FAIL_W'(MAX_FAILS - 1));

    // The timer is loaded on the same edge the FSM enters OPEN/LOCKOUT so the
    // timed state lasts exactly the configured number of cycles.
    assign tmr_load  = code_ok || fails_full;
    assign tmr_value = code_ok ? TMR_W'(UNLOCK_CYCLES - 1) : TMR_W'(LOCKOUT_CYCLES - 1);

    always_comb begin
        shadow_upd = shadow_q;
        shadow_upd[4*int'(idx_q) +: 4] = sym;
    end

    lock_timer #(.WIDTH(TMR_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .done       (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ENTRY;
            code_q     <= DEFAULT_CODE;
            shadow_q   <= '0;
            idx_q      <= '0;
            mismatch_q <= 1'b0;
            fail_q     <= '0;
            display_q  <= '0;
            points_q   <= '0;
            enable_q   <= '0;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            case (state_q)
                ENTRY: begin
                    if (any_strobe) begin
                        if (last_slot) begin
                            idx_q      <= '0;
                            mismatch_q <= 1'b0;
                            display_q  <= '0;
                            enable_q   <= '0;
                            if (code_ok) begin
                                state_q    <= OPEN;
                                fail_q     <= '0;
                                unlocked_q <= 1'b1;
                                display_q  <= {NUM_DIGITS{DIG_OPEN}};
                                enable_q   <= '1;
                                points_q   <= '1;
                            end else begin
                                if (fail_q != FAIL_W'(MAX_FAILS)) fail_q <= fail_q + 1'b1;
                                if (fails_full) begin
                                    state_q   <= LOCKOUT;
                                    lockout_q <= 1'b1;
                                    display_q <= {NUM_DIGITS{DIG_LOCK}};
                                    enable_q  <= '1;
                                end
                            end
                        end else begin
                            display_q[4*int'(idx_q) +: 4] <= valid_sym ? sym : DIG_BAD;
                            enable_q[idx_q]               <= 1'b1;
                            if (sym_miss) mismatch_q <= 1'b1;
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end

                OPEN: begin
                    if (bus.program_req) begin
                        state_q    <= PROGRAM;
                        unlocked_q <= 1'b0;
                        display_q  <= '0;
                        enable_q   <= '0;
                        points_q   <= '1;
                        idx_q      <= '0;
                    end else if (any_strobe || tmr_done) begin
                        state_q    <= ENTRY;
                        unlocked_q <= 1'b0;
                        display_q  <= '0;
                        enable_q   <= '0;
                        points_q   <= '0;
                        idx_q      <= '0;
                        mismatch_q <= 1'b0;
                    end
                end

                PROGRAM: begin
                    if (valid_sym) begin
                        if (last_slot) begin
                            code_q     <= shadow_upd;
                            state_q    <= ENTRY;
                            display_q  <= '0;
                            enable_q   <= '0;
                            points_q   <= '0;
                            idx_q      <= '0;
                            mismatch_q <= 1'b0;
                        end else begin
                            shadow_q                      <= shadow_upd;
                            display_q[4*int'(idx_q) +: 4] <= sym;
                            enable_q[idx_q]               <= 1'b1;
                            idx_q                         <= idx_q + 1'b1;
                        end
                    end
                end

                LOCKOUT: begin
                    if (tmr_done) begin
                        state_q    <= ENTRY;
                        fail_q     <= '0;
                        lockout_q  <= 1'b0;
                        display_q  <= '0;
                        enable_q   <= '0;
                        points_q   <= '0;
                        idx_q      <= '0;
                        mismatch_q <= 1'b0;
                    end
                end

                default: state_q <= ENTRY;
            endcase
        end
    end

    assign bus.display       = display_q;
    assign bus.points        = points_q;
    assign bus.enable_digits = enable_q;
    assign bus.unlocked      = unlocked_q;
    assign bus.lockout       = lockout_q;

endmodule

// File: doc/lock_fsm_multi.md
Name: lock_fsm_multi

Overview:
Parametrised successor to the fixed 4-button combination lock. Consumes single-cycle button strobes from the per-button edge detectors and checks a CODE_LEN-symbol code held in a reprogrammable register. Adds fail counting with timed lockout, timed auto-relock and a code-programming mode. Drives the seven-segment controller's digits, decimal-point and enable inputs plus unlocked and lockout status.

Parameters:
NUM_BUTTONS, 4, number of strobe inputs; symbol = button index; legal range 2..16
CODE_LEN, 4, symbols per code; must satisfy 1 <= CODE_LEN <= NUM_DIGITS
NUM_DIGITS, 4, seven-segment digits driven, 4 bits each
DEFAULT_CODE, 16'h3210, reset code; symbol j = DEFAULT_CODE[4j+3:4j]; width 4*CODE_LEN
MAX_FAILS, 3, consecutive wrong codes before lockout; >= 1
UNLOCK_CYCLES, 50_000_000, clk cycles OPEN lasts before auto-relock
LOCKOUT_CYCLES, 100_000_000, clk cycles LOCKOUT lasts

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
strobes  in  NUM_BUTTONS  one-cycle pulses, one bit per button
program_req  in  1  one-cycle pulse; requests code programming
display  out  4*NUM_DIGITS  digit nibbles; digit k = display[4k+3:4k]
points  out  NUM_DIGITS  decimal points, 1 = lit
enable_digits  out  NUM_DIGITS  digit enables, 1 = shown
unlocked  out  1  high in OPEN
lockout  out  1  high in LOCKOUT

Behaviour:
- One clock (clk). Reset is synchronous and active-high. All state and outputs are registered; response is visible the cycle after the triggering strobe.
- Reset values: state ENTRY, code register = DEFAULT_CODE, entry index 0, mismatch flag 0, fail count 0, timer 0. Outputs: display 0, points 0, enable_digits 0, unlocked 0, lockout 0.
- Reset asserted mid-operation, in any state, restores all reset values, including the code register.
- Symbol validity: a strobe word with exactly one bit set is a valid symbol. An all-zero word is no event. A multi-hot word is an invalid entry.
- ENTRY:
  - Each valid or invalid entry stores its symbol at digit [index] and sets enable_digits[index]. An invalid entry displays 4'hF.
  - An entry sets the mismatch flag if it is invalid or differs from code symbol [index]. Index then increments.
  - On the CODE_LEN-th entry, with a match: go to OPEN, fail count := 0.
  - On the CODE_LEN-th entry, with a mismatch: fail count increments. If it reaches MAX_FAILS, go to LOCKOUT; otherwise stay in ENTRY.
  - Either way, clear index, mismatch flag, display and enables.
  - program_req is ignored in ENTRY.
- OPEN:
  - unlocked = 1. All digits enabled, display all 4'h0, points all 1.
  - Timer loads UNLOCK_CYCLES-1 on entry and decrements each cycle.
  - Timer reaching 0: go to ENTRY.
  - Any non-zero strobe word: immediate relock to ENTRY; the strobe is consumed and not counted as an entry.
  - program_req: go to PROGRAM. When program_req and a strobe arrive in the same cycle, program_req wins and the strobe is discarded.
- PROGRAM:
  - points all 1. Digits show the shadow entries with the same indexing as ENTRY.
  - Only valid symbols are accepted; multi-hot words are ignored.
  - After CODE_LEN accepted symbols, the shadow is committed to the code register in one cycle and the state returns to ENTRY (cleared).
  - No timeout. program_req is ignored.
- LOCKOUT:
  - lockout = 1. All digits enabled, showing 4'hE; points 0.
  - Timer loads LOCKOUT_CYCLES-1 on entry. Strobes and program_req are ignored.
  - Timer reaching 0: go to ENTRY, fail count := 0.
- Widths: index and counters use $clog2 of their maximum. Timer width is $clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES)). No wrap: index never exceeds CODE_LEN-1, and the fail count saturates at MAX_FAILS.

Decomposition:
- Package lock_pkg: state enum (ENTRY, OPEN, PROGRAM, LOCKOUT); display constants DIG_BAD = 4'hF, DIG_LOCK = 4'hE, DIG_OPEN = 4'h0; onehot-to-index function.
- Sub-module lock_timer: loadable down-counter with load and done ports; a single instance is shared by OPEN and LOCKOUT.

Test Plan:
All scenarios use default parameters with UNLOCK_CYCLES=20 and LOCKOUT_CYCLES=50.
- After reset, strobe 0001, 0010, 0100, 1000 -> unlocked=1 the cycle after the 4th strobe, display 16'h0000, points 4'hF. Exactly 20 cycles later -> unlocked=0, state ENTRY.
- Enter sequence 0,1,3,2 -> after 3rd strobe enable_digits=4'b0111, display[11:0]=12'h310. After 4th -> unlocked stays 0, enables clear, fails=1.
- Three wrong codes -> lockout=1, display 16'hEEEE. Strobes during lockout have no effect. After 50 cycles -> lockout=0. The correct code then unlocks.
- Unlock, then program_req plus strobe 0010 in the same cycle -> PROGRAM. Enter 3,3,1,0 -> code becomes 16'h0133. Old code fails; sequence 3,3,1,0 unlocks.
- Multi-hot strobe 0011 as 2nd entry -> digit1 shows 4'hF; the code fails even if the other entries are correct.
- Assert reset during PROGRAM after 2 symbols -> all outputs 0 and code back to 16'h3210.
